// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared constants and types for the WS2812 RZ decoder.
// Default timing assumes a 50 MHz system clock.
package ws2812_pkg;

    localparam int GRB_W           = 24;
    localparam int T0H_CYC         = 17;
    localparam int T1H_CYC         = 35;
    localparam int HIGH_THRESH_CYC = 26;
    localparam int MIN_HIGH_CYC    = 8;
    localparam int MAX_HIGH_CYC    = 50;
    localparam int RESET_CYC       = 2500;

    typedef enum logic [1:0] {
        WAIT_GAP,
        IDLE,
        HIGH,
        LOW
    } dec_state_t;

endpackage

// File: rtl/rz_sync_edge.sv
// rz_sync_edge: two-flop synchronizer for the RZ line
// with one-cycle rise and fall strobes on the synchronized level.
module rz_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s_d;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= din;
            s   <= s1;
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/ws2812_rz_decoder.sv
// ws2812_rz_decoder: classifies RZ high pulses into bits, assembles
// MSB-first GRB words and flags reset-gap latches and timing errors.
module ws2812_rz_decoder
    import ws2812_pkg::*;
#(
    parameter int HIGH_THRESH  = HIGH_THRESH_CYC,
    parameter int MIN_HIGH     = MIN_HIGH_CYC,
    parameter int MAX_HIGH     = MAX_HIGH_CYC,
    parameter int RESET_CYCLES = RESET_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rz_in,
    output logic [GRB_W-1:0]  rgb_data,
    output logic              rgb_valid,
    output logic              latch,
    output logic [7:0]        frame_words,
    output logic              pulse_err
);

    localparam int CW = $clog2(RESET_CYCLES + 1);

    localparam logic [CW-1:0] RST_C  = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] RST_M1 = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] MIN_C  = CW'(MIN_HIGH);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_HIGH);
    localparam logic [CW-1:0] THR_C  = CW'(HIGH_THRESH);
    localparam logic [4:0]    LAST_B = 5'(GRB_W - 1);

    logic s;
    logic rise;
    logic fall;

    dec_state_t         state;
    logic [CW-1:0]      low_cnt;
    logic [CW-1:0]      high_cnt;
    logic [GRB_W-2:0]   shreg;
    logic [4:0]         bit_cnt;
    logic               frame_active;
    logic               bit_v;

    rz_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rz_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    assign bit_v = (high_cnt >= THR_C);

    // Pulse classifier, word assembler and gap/latch tracker
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= WAIT_GAP;
            low_cnt      <= '0;
            high_cnt     <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            frame_active <= 1'b0;
            rgb_data     <= '0;
            rgb_valid    <= 1'b0;
            latch        <= 1'b0;
            frame_words  <= '0;
            pulse_err    <= 1'b0;
        end else begin
            rgb_valid <= 1'b0;
            latch     <= 1'b0;
            pulse_err <= 1'b0;

            // frame_words is held for the latch cycle, cleared after
            if (latch) begin
                frame_words  <= '0;
                frame_active <= 1'b0;
            end

            unique case (state)
                WAIT_GAP: begin
                    if (s) begin
                        low_cnt <= '0;
                    end else if (low_cnt == RST_M1) begin
                        low_cnt <= RST_C;
                        state   <= IDLE;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= CW'(1);
                        low_cnt  <= '0;
                    end else if (low_cnt != RST_C) begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        if (high_cnt < MIN_C) begin
                            pulse_err    <= 1'b1;
                            bit_cnt      <= '0;
                            frame_words  <= '0;
                            frame_active <= 1'b0;
                            low_cnt      <= '0;
                            state        <= WAIT_GAP;
                        end else begin
                            shreg   <= {shreg[GRB_W-3:0], bit_v};
                            low_cnt <= CW'(1);
                            state   <= LOW;
                            if (bit_cnt == LAST_B) begin
                                rgb_data     <= {shreg, bit_v};
                                rgb_valid    <= 1'b1;
                                bit_cnt      <= '0;
                                frame_active <= 1'b1;
                                if (frame_words != 8'hFF)
                                    frame_words <= frame_words + 8'd1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else if (high_cnt == MAX_C) begin
                        pulse_err    <= 1'b1;
                        bit_cnt      <= '0;
                        frame_words  <= '0;
                        frame_active <= 1'b0;
                        low_cnt      <= '0;
                        state        <= WAIT_GAP;
                    end else begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end

                LOW: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= CW'(1);
                        low_cnt  <= '0;
                    end else if (low_cnt == RST_M1) begin
                        low_cnt <= RST_C;
                        state   <= IDLE;
                        if (frame_active)
                            latch <= 1'b1;
                        if (bit_cnt != 5'd0) begin
                            pulse_err <= 1'b1;
                            bit_cnt   <= '0;
                        end
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rz_decoder.sv
// tb_ws2812_rz_decoder: scoreboard bench for the RZ decoder.
// Words and latches are queued when driven and popped by a monitor.
module tb_ws2812_rz_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rz_in = 1'b0;
    logic [23:0] rgb_data;
    logic        rgb_valid;
    logic        latch;
    logic [7:0]  frame_words;
    logic        pulse_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int last_lat = 0;
    int err_cnt = 0;
    int valid_cnt = 0;
    int latch_cnt = 0;
    logic prev_latch = 1'b0;

    logic [23:0] exp_q[$];
    int          lat_q[$];

    localparam int GAP = 2560;

    ws2812_rz_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rz_in       (rz_in),
        .rgb_data    (rgb_data),
        .rgb_valid   (rgb_valid),
        .latch       (latch),
        .frame_words (frame_words),
        .pulse_err   (pulse_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: pops expectations as the DUT reports words and latches
    always @(posedge clk) begin
        logic [23:0] e;
        int          fw;
        #1;
        if (pulse_err) err_cnt++;
        if (rgb_valid) begin
            valid_cnt++;
            last_lat = cyc - fall_cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rgb_valid got=%h want=none", rgb_data);
            end else begin
                e = exp_q.pop_front();
                if (rgb_data !== e) begin
                    failures++;
                    $display("FAIL rgb_data got=%h want=%h", rgb_data, e);
                end
            end
        end
        if (latch) begin
            latch_cnt++;
            checks++;
            if (lat_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_latch fw=%0d want=none", frame_words);
            end else begin
                fw = lat_q.pop_front();
                if (frame_words !== 8'(fw)) begin
                    failures++;
                    $display("FAIL latch_frame_words got=%0d want=%0d", frame_words, fw);
                end
            end
            checks++;
            if (rgb_valid) begin
                failures++;
                $display("FAIL latch_with_valid got=1 want=0");
            end
        end
        if (prev_latch) begin
            checks++;
            if (frame_words !== 8'd0) begin
                failures++;
                $display("FAIL fw_after_latch got=%0d want=0", frame_words);
            end
        end
        prev_latch = latch;
    end

    task automatic pulse(input int h, input int l);
        @(negedge clk);
        rz_in = 1'b1;
        repeat (h) @(negedge clk);
        rz_in = 1'b0;
        fall_cyc = cyc;
        repeat (l - 1) @(negedge clk);
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        rz_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n,
                             input int h0, input int h1);
        for (int i = 23; i > 23 - n; i--) begin
            if (w[i]) pulse(h1, 27);
            else      pulse(h0, 45);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        exp_q.push_back(w);
        send_bits(w, 24, 17, 35);
    endtask

    task automatic check_drained(input string tag);
        checks++;
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending words=%0d latches=%0d want=0",
                     tag, exp_q.size(), lat_q.size());
        end
        exp_q.delete();
        lat_q.delete();
    endtask

    task automatic check_err(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s pulse_err got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        rz_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rgb_data, rgb_valid, latch, frame_words, pulse_err} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {rgb_data, rgb_valid, latch, frame_words, pulse_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_word;
        int e0;
        e0 = err_cnt;
        gap(GAP);
        send_word(24'hFF00FF);
        check_drained("t1_word");
        checks++;
        if (last_lat !== 3) begin
            failures++;
            $display("FAIL t1_latency got=%0d want=3", last_lat);
        end
        check_err("t1", err_cnt - e0, 0);
    endtask

    task automatic test_frame_latch;
        int l0;
        lat_q.push_back(1);
        gap(GAP);
        send_word(24'h00FF00);
        send_word(24'hA5A5A5);
        lat_q.push_back(2);
        l0 = latch_cnt;
        gap(GAP);
        check_drained("t2_frame");
        checks++;
        if (latch_cnt - l0 !== 1) begin
            failures++;
            $display("FAIL t2_latch_count got=%0d want=1", latch_cnt - l0);
        end
    endtask

    task automatic test_limits;
        int e0;
        logic [23:0] w;
        w = 24'h5A5A5A;
        exp_q.push_back({w[23:1], 1'b0});
        send_bits(w, 23, 17, 35);
        pulse(25, 45);
        exp_q.push_back({w[23:1], 1'b1});
        send_bits(w, 23, 17, 35);
        pulse(26, 45);
        exp_q.push_back(24'h0F0F0F);
        send_bits(24'h0F0F0F, 24, 8, 50);
        check_drained("t3_thresh");
        e0 = err_cnt;
        pulse(7, 45);
        check_err("t3_short", err_cnt - e0, 1);
        gap(GAP);
        e0 = err_cnt;
        pulse(60, 45);
        check_err("t3_stuck", err_cnt - e0, 1);
        send_bits(24'h777777, 24, 17, 35);
        check_drained("t3_no_word");
        gap(GAP);
        send_word(24'h3C3C3C);
        lat_q.push_back(1);
        gap(GAP);
        check_drained("t3_recover");
    endtask

    task automatic test_no_initial_gap;
        test_reset();
        send_bits(24'hFFF000, 12, 17, 35);
        gap(GAP);
        send_word(24'h123456);
        lat_q.push_back(1);
        gap(GAP);
        check_drained("t4_pregap");
    endtask

    task automatic test_partial;
        int e0;
        e0 = err_cnt;
        send_bits(24'hABCDEF, 10, 17, 35);
        gap(GAP);
        check_err("t5_part_empty", err_cnt - e0, 1);
        check_drained("t5_no_latch");
        send_word(24'h0000FF);
        send_bits(24'hABCDEF, 10, 17, 35);
        lat_q.push_back(1);
        e0 = err_cnt;
        gap(GAP);
        check_err("t5_part_frame", err_cnt - e0, 1);
        send_word(24'h9E3779);
        lat_q.push_back(1);
        gap(GAP);
        check_drained("t5_next");
    endtask

    task automatic test_mid_reset;
        int e0;
        send_bits(24'hDEADBE, 13, 17, 35);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({rgb_data, rgb_valid, latch, frame_words, pulse_err} !== 35'd0) begin
            failures++;
            $display("FAIL t6_reset_outputs got=%h want=0",
                     {rgb_data, rgb_valid, latch, frame_words, pulse_err});
        end
        e0 = err_cnt;
        send_bits(24'hDEADBE << 13, 11, 17, 35);
        send_bits(24'h111111, 24, 17, 35);
        check_drained("t6_waitgap");
        gap(GAP);
        send_word(24'hC3C3C3);
        lat_q.push_back(1);
        gap(GAP);
        check_drained("t6_after");
        check_err("t6", err_cnt - e0, 0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_frame_latch();
        test_limits();
        test_no_initial_gap();
        test_partial();
        test_mid_reset();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
